// File: rtl/dc_hyper_cdc_tx.sv
// Source-domain sender for a two-phase (toggle) req/ack bus crossing.
// Optional one-entry skid buffer enabled by defining HYPER_CDC_TX_SKID_EN.
module dc_hyper_cdc_tx #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DATA_RESET  = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             cdc_req_o,
  output logic [WIDTH-1:0] cdc_data_o,
  input  logic             cdc_ack_i,
  output logic             busy_o,
  output logic             proto_err_o
);

  typedef enum logic {IDLE, WAIT_ACK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   req_q;
  logic                   ready_en_q;
  logic                   err_q;
  logic                   done;
  logic                   accept;
  logic                   launch;
  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       launch_data;

  assign ack_s       = ack_sync_q[SYNC_STAGES-1];
  assign done        = (state_q == WAIT_ACK) && (ack_s == req_q);
  assign accept      = in_valid_i && in_ready_o;
  assign cdc_req_o   = req_q;
  assign cdc_data_o  = data_q;
  assign busy_o      = (state_q == WAIT_ACK);
  assign proto_err_o = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], cdc_ack_i};
    end
  end

`ifdef HYPER_CDC_TX_SKID_EN
  logic             buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;

  assign in_ready_o = ready_en_q && !buf_valid_q;

  // A buffered word always wins the launch slot; it can never coexist with an accept
  // because the buffer being full is exactly what deasserts in_ready_o.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_data = in_data_i;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (state_q == IDLE || done) begin
      state_d = IDLE;
      if (buf_valid_q) begin
        launch      = 1'b1;
        launch_data = buf_data_q;
        buf_valid_d = 1'b0;
        state_d     = WAIT_ACK;
      end else if (accept) begin
        launch  = 1'b1;
        state_d = WAIT_ACK;
      end
    end else if (accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign in_ready_o = ready_en_q && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_data = in_data_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          launch  = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`endif

  // Data and request change together so the receiver never sees a new toggle with old data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= DATA_RESET;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (launch) begin
        req_q  <= ~req_q;
        data_q <= launch_data;
      end
      if (state_q == IDLE && ack_s != req_q) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dc_hyper_cdc_tx.sv
// Self-checking bench for dc_hyper_cdc_tx: directed steps plus a randomized stream
// through a toggle receiver model on a 3.7x slower clock.
module tb_dc_hyper_cdc_tx;

  localparam int WIDTH = 32;
  localparam int SS    = 2;
`ifdef HYPER_CDC_TX_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rclk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             man_ack = 1'b0;
  logic             rx_en = 1'b0;
  logic             rx_ack, rs1, rs2;
  logic             cdc_ack;
  logic             in_ready_o, cdc_req_o, busy_o, proto_err_o;
  logic [WIDTH-1:0] cdc_data_o;

  int               checks = 0;
  int               errors = 0;
  int               reqToggles = 0;
  logic             lastReq;
  logic             expReq = 1'b0;
  logic [31:0]      rx_q[$];
  logic [31:0]      exp_q[$];

  assign cdc_ack = rx_en ? rx_ack : man_ack;

  dc_hyper_cdc_tx #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .DATA_RESET('0)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data),
    .cdc_req_o   (cdc_req_o),
    .cdc_data_o  (cdc_data_o),
    .cdc_ack_i   (cdc_ack),
    .busy_o      (busy_o),
    .proto_err_o (proto_err_o)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    #18 rclk = 1'b1;
    #19 rclk = 1'b0;
  end

  // Receiver model: two-flop req synchronizer, capture data whenever a new toggle arrives.
  always @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      rs1    <= 1'b0;
      rs2    <= 1'b0;
      rx_ack <= 1'b0;
    end else begin
      rs1 <= cdc_req_o;
      rs2 <= rs1;
      if (rx_en && rs2 != rx_ack) begin
        rx_ack <= rs2;
        rx_q.push_back(cdc_data_o);
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lastReq <= 1'b0;
    end else begin
      if (cdc_req_o !== lastReq) reqToggles <= reqToggles + 1;
      lastReq <= cdc_req_o;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  task automatic doReset();
    rstn    = 1'b0;
    man_ack = 1'b0;
    #1;
    checkOutput("rst_req", cdc_req_o, 0);
    checkOutput("rst_data", cdc_data_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_err", proto_err_o, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", in_ready_o, 1);
    expReq = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(1'b1, w);
    @(negedge clk);
    applyStimulus(1'b0, $urandom);
    expReq = ~expReq;
    checkOutput("send_req", cdc_req_o, expReq);
    checkOutput("send_data", cdc_data_o, w);
    checkOutput("send_busy", busy_o, 1);
  endtask

  task automatic ackAndWait(input string tag);
    int n;
    man_ack = expReq;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o !== 1'b0 && n < 50);
    checkOutput(tag, n, SS + 1);
  endtask

  initial begin
    int          n;
    logic        stable, acc, busyDrop;
    logic [31:0] w, wa, wb, wc;
    int          base;

    // Reset with a word already offered; exactly one word must go out afterwards.
    applyStimulus(1'b1, 32'hDEAD_BEEF);
    doReset();
    sendWord(32'hDEAD_BEEF);
    ackAndWait("rst_first_done");
    repeat (4) @(negedge clk);
    checkOutput("rst_one_word", cdc_req_o, 1);

    // Single transfer with ack three cycles after the request.
    w = 32'h1234_5678;
    sendWord(w);
    checkOutput("single_ready_low", in_ready_o, SKID);
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cdc_data_o !== w) stable = 1'b0;
    end
    man_ack = expReq;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (cdc_data_o !== w) stable = 1'b0;
    end while (!(busy_o === 1'b0 && in_ready_o === 1'b1) && n < 50);
    checkOutput("single_ready_latency", n, SS + 1);
    checkOutput("single_data_stable", stable, 1);
    checkOutput("single_err", proto_err_o, 0);

    // Reset while a transfer is outstanding, then a normal send.
    sendWord($urandom);
    doReset();
    sendWord($urandom);
    ackAndWait("mid_after_done");
    checkOutput("mid_err", proto_err_o, 0);

    // Spurious ack while idle sets a sticky error.
    man_ack = ~expReq;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (proto_err_o !== 1'b1 && n < 50);
    checkOutput("spur_latency", n, SS + 1);
    repeat (5) @(negedge clk);
    checkOutput("spur_sticky", proto_err_o, 1);
    doReset();

    // Stream 16 words through the slow receiver with random gaps.
    rx_en = 1'b1;
    doReset();
    rx_q.delete();
    exp_q.delete();
    base = reqToggles;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(1'b1, 32'(i));
      acc = 1'b0;
      for (int k = 0; k < 500 && !acc; k++) begin
        acc = in_ready_o;
        @(negedge clk);
      end
      applyStimulus(1'b0, $urandom);
      checkOutput("stream_accept", acc, 1);
      exp_q.push_back(32'(i));
    end
    for (int k = 0; k < 3000 && rx_q.size() < 16; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    checkOutput("stream_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      checkOutput($sformatf("stream_word%0d", i), rx_q[i], exp_q[i]);
    checkOutput("stream_toggles", reqToggles - base, 16);
    checkOutput("stream_err", proto_err_o, 0);
    checkOutput("stream_idle", busy_o, 0);
    rx_en = 1'b0;

`ifdef HYPER_CDC_TX_SKID_EN
    // Back-to-back A, B, C: B buffered, launched on A's completion, C waits for room.
    doReset();
    wa = $urandom;
    wb = wa + 32'd1;
    wc = wa + 32'd2;
    applyStimulus(1'b1, wa);
    @(negedge clk);
    expReq = ~expReq;
    checkOutput("skid_a_req", cdc_req_o, expReq);
    checkOutput("skid_a_ready", in_ready_o, 1);
    applyStimulus(1'b1, wb);
    @(negedge clk);
    checkOutput("skid_b_buffered", in_ready_o, 0);
    checkOutput("skid_a_hold", cdc_data_o, wa);
    applyStimulus(1'b1, wc);
    man_ack  = expReq;
    busyDrop = 1'b0;
    n = 0;
    while (cdc_data_o !== wb && n < 50) begin
      @(negedge clk);
      n++;
      if (busy_o !== 1'b1) busyDrop = 1'b1;
    end
    expReq = ~expReq;
    checkOutput("skid_b_launch", cdc_data_o, wb);
    checkOutput("skid_b_req", cdc_req_o, expReq);
    @(negedge clk);
    checkOutput("skid_c_accepted", in_ready_o, 0);
    applyStimulus(1'b0, $urandom);
    man_ack = expReq;
    n = 0;
    while (cdc_data_o !== wc && n < 50) begin
      @(negedge clk);
      n++;
      if (busy_o !== 1'b1) busyDrop = 1'b1;
    end
    expReq = ~expReq;
    checkOutput("skid_c_launch", cdc_data_o, wc);
    checkOutput("skid_busy_held", busyDrop, 0);
    ackAndWait("skid_c_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
